axi_wdata_router: RTL and testbench

- Write-data stage directly downstream of the write-order FIFO.
- The AW arbiter pushes the granted master index into that FIFO. This block pops one index per burst and routes that master's W channel to the single slave W port until the WLAST handshake.
- This keeps W beats in AW grant order.

---
 rtl/axi_wdata_router.sv | 130 +++++++++++++
 tb/tb_axi_wdata_router.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wdata_router.sv
// W-channel router: pops one master index per burst from the write-order FIFO
// and forwards that master's W beats to the single slave port until WLAST.
module axi_wdata_router #(
  parameter int NM = 4,
  parameter int DW = 32,
  parameter int SW = 2,
  parameter int BW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [SW-1:0]        i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_pop,
  input  logic [NM-1:0]        i_m_wvalid,
  input  logic [NM*DW-1:0]     i_m_wdata,
  input  logic [NM*DW/8-1:0]   i_m_wstrb,
  input  logic [NM-1:0]        i_m_wlast,
  output logic [NM-1:0]        o_m_wready,
  output logic                 o_s_wvalid,
  output logic [DW-1:0]        o_s_wdata,
  output logic [DW/8-1:0]      o_s_wstrb,
  output logic                 o_s_wlast,
  input  logic                 i_s_wready,
  output logic [BW-1:0]        o_beat_cnt,
  output logic                 o_err
);

  localparam int unsigned NM_U = NM;
  localparam int unsigned SB   = DW / 8;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_sel;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_err;

  logic            w_vld;
  logic            w_last;
  logic [DW-1:0]   w_data;
  logic [SB-1:0]   w_strb;
  logic            w_hs;
  logic            w_tail;
  logic            w_pop;
  logic            w_idx_ok;

  // Selected-master mux; the loop keeps NM that is not a power of two safe.
  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_data = '0;
    w_strb = '0;
    for (int unsigned k = 0; k < NM_U; k++) begin
      if (r_sel == SW'(k)) begin
        w_vld  = i_m_wvalid[k];
        w_last = i_m_wlast[k];
        w_data = i_m_wdata[k*DW +: DW];
        w_strb = i_m_wstrb[k*SB +: SB];
      end
    end
  end

  assign w_hs     = (r_state == ST_BURST) & w_vld & i_s_wready;
  assign w_tail   = w_hs & w_last;
  assign w_pop    = ~i_fifo_empty & ((r_state == ST_IDLE) | w_tail);
  assign w_idx_ok = (32'(i_fifo_data) < NM_U);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A pop at the tail takes priority over the return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) w_state_nxt = w_idx_ok ? ST_BURST : ST_IDLE;
      end
      ST_BURST: begin
        if (w_pop)       w_state_nxt = w_idx_ok ? ST_BURST : ST_IDLE;
        else if (w_tail) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_pop = w_pop;
    o_s_wvalid = 1'b0;
    o_s_wdata  = '0;
    o_s_wstrb  = '0;
    o_s_wlast  = 1'b0;
    o_m_wready = '0;
    if (r_state == ST_BURST) begin
      o_s_wvalid = w_vld;
      o_s_wdata  = w_data;
      o_s_wstrb  = w_strb;
      o_s_wlast  = w_last;
      for (int unsigned k = 0; k < NM_U; k++) begin
        if (r_sel == SW'(k)) o_m_wready[k] = i_s_wready;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_pop) begin
      r_beat_cnt <= '0;
      if (w_idx_ok) r_sel <= i_fifo_data;
      else          r_err <= 1'b1;
    end else if (w_hs && (r_beat_cnt != '1)) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign o_beat_cnt = r_beat_cnt;
  assign o_err      = r_err;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Randomized and directed bench for axi_wdata_router against a queue-based
// model of burst ownership, grant order, beat count and error flag.
module tb_axi_wdata_router;

  localparam int NM = 3;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int BW = 3;
  localparam int SB = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW-1:0]     fifo_data;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [NM-1:0]     m_wvalid;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*SB-1:0]  m_wstrb;
  logic [NM-1:0]     m_wlast;
  logic [NM-1:0]     m_wready;
  logic              s_wvalid;
  logic [DW-1:0]     s_wdata;
  logic [SB-1:0]     s_wstrb;
  logic              s_wlast;
  logic              s_wready;
  logic [BW-1:0]     beat_cnt;
  logic              err;

  always #5 clk = ~clk;

  axi_wdata_router #(.NM(NM), .DW(DW), .SW(SW), .BW(BW)) dut (
    .i_clk        (clk),
    .i_resetn     (rst_n),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_pop   (fifo_pop),
    .i_m_wvalid   (m_wvalid),
    .i_m_wdata    (m_wdata),
    .i_m_wstrb    (m_wstrb),
    .i_m_wlast    (m_wlast),
    .o_m_wready   (m_wready),
    .o_s_wvalid   (s_wvalid),
    .o_s_wdata    (s_wdata),
    .o_s_wstrb    (s_wstrb),
    .o_s_wlast    (s_wlast),
    .i_s_wready   (s_wready),
    .o_beat_cnt   (beat_cnt),
    .o_err        (err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SB-1:0] s;
    logic          l;
  } beat_t;

  beat_t       mq[NM][$];
  int          fifo_q[$];
  int          rdy_q[$];
  bit [NM-1:0] acc;
  int          owner;
  int          mcnt;
  bit          merr;
  int          vpct;
  int          rpct;
  int          checks;
  int          errors;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Owner is the master whose burst is in flight (-1 when none).
  task automatic model_step();
    logic          ev, el, hs, tail, ep;
    logic [DW-1:0] ed;
    logic [SB-1:0] es;
    logic [NM-1:0] er;
    int            idx;
    ev = 1'b0; el = 1'b0; ed = '0; es = '0; er = '0;
    if (owner >= 0) begin
      ev = m_wvalid[owner];
      el = m_wlast[owner];
      ed = m_wdata[owner*DW +: DW];
      es = m_wstrb[owner*SB +: SB];
      if (s_wready) er[owner] = 1'b1;
    end
    hs   = ev && s_wready;
    tail = hs && el;
    ep   = !fifo_empty && (owner < 0 || tail);
    chk("s_wvalid", s_wvalid, ev);
    chk("s_wdata",  s_wdata,  ed);
    chk("s_wstrb",  s_wstrb,  es);
    chk("s_wlast",  s_wlast,  el);
    chk("m_wready", m_wready, er);
    chk("fifo_pop", fifo_pop, ep);
    chk("beat_cnt", beat_cnt, mcnt);
    chk("err",      err,      merr);
    acc = '0;
    if (hs) begin
      acc[owner] = 1'b1;
      if (mcnt < (1 << BW) - 1) mcnt++;
    end
    if (tail) owner = -1;
    if (ep) begin
      idx = int'(fifo_data);
      void'(fifo_q.pop_front());
      mcnt = 0;
      if (idx < NM) owner = idx;
      else          merr  = 1'b1;
    end
  endtask

  // Masters hold a presented beat until it is accepted (AXI stability rule).
  task automatic present();
    beat_t b;
    bit    hold;
    for (int k = 0; k < NM; k++) begin
      hold = m_wvalid[k] && !acc[k];
      if (acc[k]) void'(mq[k].pop_front());
      if (!hold) begin
        if (mq[k].size() > 0 && $urandom_range(0, 99) < vpct) begin
          b = mq[k][0];
          m_wvalid[k]            = 1'b1;
          m_wdata[k*DW +: DW]    = b.d;
          m_wstrb[k*SB +: SB]    = b.s;
          m_wlast[k]             = b.l;
        end else begin
          m_wvalid[k]            = 1'b0;
          m_wdata[k*DW +: DW]    = $urandom;
          m_wstrb[k*SB +: SB]    = SB'($urandom);
          m_wlast[k]             = 1'($urandom);
        end
      end
    end
    acc = '0;
    if (rdy_q.size() > 0) s_wready = 1'(rdy_q.pop_front());
    else                  s_wready = ($urandom_range(0, 99) < rpct);
    if (fifo_q.size() > 0) begin
      fifo_empty = 1'b0;
      fifo_data  = SW'(fifo_q[0]);
    end else begin
      fifo_empty = 1'b1;
      fifo_data  = SW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    present();
    #1;
  endtask

  task automatic add_burst(input int k, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = $urandom;
      b.s = SB'($urandom);
      b.l = (i == n - 1);
      mq[k].push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NM; k++) mq[k].delete();
    fifo_q.delete();
    rdy_q.delete();
    acc        = '0;
    m_wvalid   = '0;
    fifo_empty = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_d;
    int            idx;
    checks = 0; errors = 0;
    owner = -1; mcnt = 0; merr = 1'b0; acc = '0;
    vpct = 100; rpct = 100;
    rst_n = 1'b0; m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0;
    s_wready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    #1;
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_m_wready", m_wready, 0);
    chk("rst_pop",      fifo_pop, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err",      err,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Single 4-beat burst from master 2
    fifo_q.push_back(2); add_burst(2, 4);
    tick();
    chk("s1_pop",       fifo_pop, 1);
    chk("s1_idle_vld",  s_wvalid, 0);
    tick();
    chk("s1_pop_once",  fifo_pop, 0);
    chk("s1_first",     s_wvalid, 1);
    chk("s1_wready",    m_wready, 3'b100);
    repeat (4) tick();
    chk("s1_cnt",       beat_cnt, 4);
    chk("s1_idle",      s_wvalid, 0);

    // Back-to-back {1,2}; master 0 asserts wvalid without a grant
    fifo_q.push_back(1); fifo_q.push_back(2);
    add_burst(1, 2); add_burst(2, 3); add_burst(0, 2);
    tick();
    chk("s2_pop",       fifo_pop, 1);
    tick();
    chk("s2_guard",     m_wready, 3'b010);
    chk("s2_m0_vld",    m_wvalid[0], 1);
    chk("s2_data",      s_wdata, mq[1][0].d);
    tick();
    chk("s2_tail_pop",  fifo_pop, 1);
    chk("s2_tail_last", s_wlast, 1);
    exp_d = mq[2][0].d;
    tick();
    chk("s2_nobubble",  s_wvalid, 1);
    chk("s2_m2_data",   s_wdata, exp_d);
    chk("s2_m2_rdy",    m_wready, 3'b100);
    repeat (3) tick();
    chk("s2_cnt",       beat_cnt, 3);
    clear_all();
    tick();

    // Backpressure 1,0,0,1 during a 3-beat burst
    fifo_q.push_back(0); add_burst(0, 3);
    rdy_q = '{0, 1, 0, 0, 1, 1};
    tick();
    tick();
    chk("s3_vld",       s_wvalid, 1);
    tick();
    exp_d = mq[0][0].d;
    chk("s3_stall_d1",  s_wdata, exp_d);
    chk("s3_stall_c1",  beat_cnt, 1);
    tick();
    chk("s3_stall_d2",  s_wdata, exp_d);
    chk("s3_stall_c2",  beat_cnt, 1);
    repeat (3) tick();
    chk("s3_cnt",       beat_cnt, 3);

    // Out-of-range index 3 followed by a valid index 1
    fifo_q.push_back(3); fifo_q.push_back(1); add_burst(1, 1);
    tick();
    chk("s4_pop_bad",   fifo_pop, 1);
    chk("s4_no_vld",    s_wvalid, 0);
    tick();
    chk("s4_err",       err, 1);
    chk("s4_idle",      s_wvalid, 0);
    chk("s4_pop_next",  fifo_pop, 1);
    tick();
    chk("s4_serviced",  m_wready, 3'b010);
    tick();
    chk("s4_cnt",       beat_cnt, 1);
    chk("s4_err_hold",  err, 1);

    // Beat counter saturation (BW=3 -> 7) on a 9-beat burst
    fifo_q.push_back(0); add_burst(0, 9);
    tick();
    repeat (10) tick();
    chk("s5_sat",       beat_cnt, 7);

    // Reset after beat 2 of 4
    fifo_q.push_back(2); add_burst(2, 4);
    repeat (4) tick();
    rst_n = 1'b0;
    clear_all();
    owner = -1; mcnt = 0; merr = 1'b0;
    #1;
    chk("s6_vld",       s_wvalid, 0);
    chk("s6_rdy",       m_wready, 0);
    chk("s6_cnt",       beat_cnt, 0);
    chk("s6_err",       err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("s6_idle",      s_wvalid, 0);
    chk("s6_nopop",     fifo_pop, 0);

    // Randomized traffic with gaps, backpressure and occasional bad indices
    vpct = 70; rpct = 70;
    repeat (3000) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 99) < 25) begin
        idx = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, NM - 1));
        fifo_q.push_back(idx);
        if (idx < NM) add_burst(idx, int'($urandom_range(1, 6)));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
